unary_stream_driver: RTL and testbench
======================================

Name: unary_stream_driver

Overview:
- Initiator side of the serial unary-add interface: accepts two binary operands and emits them as thermometer-coded bitstreams on A/B with en high (write phase).
- Then raises read_or_write, collects the adder's unary dout stream and C flag, and returns the binary sum through a valid/ready result port.
- Sits between the controller (binary domain) and the unary adder core; one transaction in flight.

Parameters:
FRAME_LEN, 15, bits per operand stream; max encodable operand value
CNT_W, 5, operand width; must cover at least FRAME_LEN
SUM_W, 5, result width; must cover at least 2*FRAME_LEN
RD_LEN, 30, read-window length in cycles; must be at least 2*FRAME_LEN

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start_valid  in  1  operand request
start_ready  out  1  high only in IDLE
a_val  in  CNT_W  operand A, binary
b_val  in  CNT_W  operand B, binary
A  out  1  unary stream A to adder
B  out  1  unary stream B to adder
en  out  1  adder enable
read_or_write  out  1  0 = adder accumulates, 1 = adder outputs its count
dout  in  1  unary result stream from adder
C  in  1  adder carry/overflow indication
res_valid  out  1  result available
res_ready  in  1  result accepted
res_sum  out  SUM_W  number of ones counted on dout
res_ovf  out  1  operand clamped, or C seen during READ
res_err  out  1  dout ones not contiguous

Behaviour:
- Reset (asynchronous, any state): state=IDLE. A=B=en=read_or_write=0, start_ready=1, res_valid=0, res_sum=0, res_ovf=0, res_err=0. Partial results are discarded.
- All outputs are registered. Bit index k and read counter r are internal.
- IDLE:
  - start_ready=1, en=0.
  - On start_valid&&start_ready: latch min(a_val,FRAME_LEN) and min(b_val,FRAME_LEN). If either operand was clamped, set the ovf flag.
  - Clear the sum, err and previous-dout registers; k=0; go to SEND.
- SEND (exactly FRAME_LEN cycles):
  - en=1, read_or_write=0.
  - A=(k<a_lat), B=(k<b_lat): ones first, then zeros. Example: value 3 gives 111000000000000.
  - k increments each cycle. After k=FRAME_LEN-1, go to TURN.
- TURN (1 cycle): en=1, A=B=0, read_or_write=1. Gives the adder one cycle to switch direction. Then r=0, go to READ.
- READ (exactly RD_LEN cycles):
  - en=1, read_or_write=1, A=B=0.
  - Each cycle, if dout=1, increment the sum, saturating at 2^SUM_W-1.
  - If dout=1 and any earlier READ sample was 0, set err.
  - If C=1, set ovf (sticky).
  - After r=RD_LEN-1, go to DONE.
- DONE:
  - en=0, read_or_write=0, res_valid=1. res_sum, res_ovf and res_err are stable until the handshake.
  - On res_valid&&res_ready: res_valid=0, go to IDLE. start_ready returns to 1 the following cycle.
  - No start is accepted in the same cycle as the result handshake.
- Latency: accept edge E0; bit 0 on A/B after E0. read_or_write rises FRAME_LEN edges later. res_valid rises at E0+FRAME_LEN+1+RD_LEN+1 (47 edges with defaults).
- start_valid is ignored outside IDLE. Operand changes after acceptance have no effect.
- res_ready is ignored while res_valid=0.
- Operand 0 gives an all-zero stream with en still high for FRAME_LEN cycles.

Test Plan:
- a=3, b=2; model adder returns 5 ones then zeros, C=0 -> A=111000000000000, B=110000000000000. read_or_write rises after 15 SEND cycles. res_sum=5, res_ovf=0, res_err=0. res_valid 47 edges after accept.
- a=0, b=0; dout all 0 -> A=B=0 for 15 cycles with en=1. res_sum=0, res_ovf=0, res_err=0.
- a=15, b=15; model returns 30 ones and pulses C once -> res_sum=30, res_ovf=1. Second case a=20, b=1 -> A all ones for 15 bits, res_ovf=1.
- dout pattern 1,1,0,1 then zeros -> res_sum=3, res_err=1.
- Hold res_ready=0 for 10 cycles in DONE -> res_valid, res_sum, res_ovf and res_err are stable; start_ready=0; start_valid is ignored. Raise res_ready -> res_valid=0, then start_ready=1.
- Assert rst_n=0 mid-SEND (k=7) -> A, B, en, read_or_write and res_valid go to 0 immediately and start_ready=1. A fresh a=1, b=1 run then gives res_sum=2.

Source files
------------

// File: rtl/unary_stream_driver.sv
// Initiator for the serial unary adder: streams two thermometer-coded operands,
// then reads back the unary sum and returns it in binary over a valid/ready port.
module unary_stream_driver #(
  parameter int FRAME_LEN = 15,
  parameter int CNT_W     = 5,
  parameter int SUM_W     = 5,
  parameter int RD_LEN    = 30
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [CNT_W-1:0] a_val,
  input  logic [CNT_W-1:0] b_val,
  output logic             A,
  output logic             B,
  output logic             en,
  output logic             read_or_write,
  input  logic             dout,
  input  logic             C,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [SUM_W-1:0] res_sum,
  output logic             res_ovf,
  output logic             res_err
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_SEND = 3'd1;
  localparam logic [2:0] S_TURN = 3'd2;
  localparam logic [2:0] S_READ = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam int RD_W = $clog2(RD_LEN + 1);
  localparam logic [CNT_W-1:0] FRAME_MAX = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST_K    = CNT_W'(FRAME_LEN - 1);
  localparam logic [RD_W-1:0]  LAST_R    = RD_W'(RD_LEN - 1);

  logic [2:0]       state;
  logic [CNT_W-1:0] k;
  logic [CNT_W-1:0] k_next;
  logic [RD_W-1:0]  r;
  logic [CNT_W-1:0] a_lat;
  logic [CNT_W-1:0] b_lat;
  logic [CNT_W-1:0] a_in;
  logic [CNT_W-1:0] b_in;
  logic             a_clip;
  logic             b_clip;
  logic             seen_zero;

  always_comb begin
    a_clip = a_val > FRAME_MAX;
    b_clip = b_val > FRAME_MAX;
    a_in   = a_clip ? FRAME_MAX : a_val;
    b_in   = b_clip ? FRAME_MAX : b_val;
    k_next = k + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      k             <= '0;
      r             <= '0;
      a_lat         <= '0;
      b_lat         <= '0;
      seen_zero     <= 1'b0;
      A             <= 1'b0;
      B             <= 1'b0;
      en            <= 1'b0;
      read_or_write <= 1'b0;
      start_ready   <= 1'b1;
      res_valid     <= 1'b0;
      res_sum       <= '0;
      res_ovf       <= 1'b0;
      res_err       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          // Bit 0 is driven straight from the accepted operands so it appears
          // on the edge that accepts them.
          if (start_valid) begin
            a_lat         <= a_in;
            b_lat         <= b_in;
            res_ovf       <= a_clip | b_clip;
            res_sum       <= '0;
            res_err       <= 1'b0;
            seen_zero     <= 1'b0;
            k             <= '0;
            A             <= (a_in != '0);
            B             <= (b_in != '0);
            en            <= 1'b1;
            read_or_write <= 1'b0;
            start_ready   <= 1'b0;
            state         <= S_SEND;
          end
        end
        S_SEND: begin
          if (k == LAST_K) begin
            A             <= 1'b0;
            B             <= 1'b0;
            read_or_write <= 1'b1;
            state         <= S_TURN;
          end else begin
            k <= k_next;
            A <= (k_next < a_lat);
            B <= (k_next < b_lat);
          end
        end
        S_TURN: begin
          r     <= '0;
          state <= S_READ;
        end
        S_READ: begin
          if (dout) begin
            if (res_sum != '1) res_sum <= res_sum + SUM_W'(1);
            if (seen_zero) res_err <= 1'b1;
          end else begin
            seen_zero <= 1'b1;
          end
          if (C) res_ovf <= 1'b1;
          if (r == LAST_R) begin
            en            <= 1'b0;
            read_or_write <= 1'b0;
            state         <= S_DONE;
          end else begin
            r <= r + RD_W'(1);
          end
        end
        S_DONE: begin
          // First DONE cycle only publishes the result; the handshake follows.
          if (!res_valid) begin
            res_valid <= 1'b1;
          end else if (res_ready) begin
            res_valid   <= 1'b0;
            start_ready <= 1'b1;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_unary_stream_driver.sv
// Scoreboard bench for unary_stream_driver: stimulus pushes expected results,
// a forked monitor pops and compares on each result handshake.
module tb_unary_stream_driver;

  localparam int FL = 15;
  localparam int RL = 30;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_valid;
  logic       start_ready;
  logic [4:0] a_val;
  logic [4:0] b_val;
  logic       A;
  logic       B;
  logic       en;
  logic       read_or_write;
  logic       dout;
  logic       C;
  logic       res_valid;
  logic       res_ready;
  logic [4:0] res_sum;
  logic       res_ovf;
  logic       res_err;

  typedef struct {
    int sum;
    int ovf;
    int err;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  unary_stream_driver #(
    .FRAME_LEN(FL),
    .CNT_W(5),
    .SUM_W(5),
    .RD_LEN(RL)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start_valid(start_valid),
    .start_ready(start_ready),
    .a_val(a_val),
    .b_val(b_val),
    .A(A),
    .B(B),
    .en(en),
    .read_or_write(read_or_write),
    .dout(dout),
    .C(C),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_sum(res_sum),
    .res_ovf(res_ovf),
    .res_err(res_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!start_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("start_ready_wait", int'(start_ready), 1);
  endtask

  task automatic run_txn(input int a, input int b, input logic [RL-1:0] pat,
                         input logic [RL-1:0] cpat, input int hold);
    int ac, bc, s, e, o;
    bit zero_seen, ctl_bad, stable_bad;
    logic [FL-1:0] got_a, got_b, exp_a, exp_b;
    logic [4:0] h_sum;
    logic h_ovf, h_err;
    exp_t x;
    ac = (a > FL) ? FL : a;
    bc = (b > FL) ? FL : b;
    for (int i = 0; i < FL; i++) begin
      exp_a[i] = (i < ac);
      exp_b[i] = (i < bc);
    end
    s = 0; e = 0; zero_seen = 0;
    for (int j = 0; j < RL; j++) begin
      if (pat[j]) begin
        if (s < 31) s++;
        if (zero_seen) e = 1;
      end else zero_seen = 1;
    end
    o = (a > FL || b > FL || cpat != '0) ? 1 : 0;

    wait_ready();
    start_valid = 1'b1;
    a_val = 5'(a);
    b_val = 5'(b);
    x.sum = s; x.ovf = o; x.err = e;
    sb.push_back(x);
    @(negedge clk);
    start_valid = 1'b0;
    a_val = 5'($urandom);
    b_val = 5'($urandom);
    ctl_bad = 0;
    for (int i = 0; i < FL; i++) begin
      got_a[i] = A;
      got_b[i] = B;
      if (!en || read_or_write) ctl_bad = 1;
      if (i < FL - 1) @(negedge clk);
    end
    check("stream_a", int'(got_a), int'(exp_a));
    check("stream_b", int'(got_b), int'(exp_b));
    check("send_ctl_bad", int'(ctl_bad), 0);
    @(negedge clk);
    check("turn_ctl", int'({en, read_or_write, A, B}), 4'b1100);
    @(negedge clk);
    ctl_bad = 0;
    for (int j = 0; j < RL; j++) begin
      dout = pat[j];
      C = cpat[j];
      if (!en || !read_or_write || A || B || res_valid) ctl_bad = 1;
      @(negedge clk);
    end
    dout = 1'b0;
    C = 1'b0;
    check("read_ctl_bad", int'(ctl_bad), 0);
    check("res_valid_early", int'(res_valid), 0);
    @(negedge clk);
    check("res_valid_latency", int'(res_valid), 1);
    check("done_ctl", int'({start_ready, en, read_or_write}), 0);

    h_sum = res_sum; h_ovf = res_ovf; h_err = res_err;
    stable_bad = 0;
    if (hold > 0) begin
      start_valid = 1'b1;
      a_val = 5'($urandom);
      b_val = 5'($urandom);
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (!res_valid || start_ready || res_sum != h_sum || res_ovf != h_ovf ||
          res_err != h_err || en)
        stable_bad = 1;
    end
    check("done_stable_bad", int'(stable_bad), 0);
    start_valid = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("res_valid_after_hs", int'(res_valid), 0);
    check("start_ready_after_hs", int'(start_ready), 1);
  endtask

  task automatic reset_mid_send();
    wait_ready();
    start_valid = 1'b1;
    a_val = 5'd12;
    b_val = 5'd10;
    @(negedge clk);
    start_valid = 1'b0;
    repeat (7) @(negedge clk);
    check("a_bit7_before_reset", int'(A), 1);
    #1 rst_n = 1'b0;
    #1;
    check("async_reset_outs", int'({A, B, en, read_or_write, res_valid}), 0);
    check("async_reset_start_ready", int'(start_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [RL-1:0] ones(input int n);
    logic [RL-1:0] p;
    for (int j = 0; j < RL; j++) p[j] = (j < n);
    return p;
  endfunction

  initial begin
    int a, b, n, mode;
    logic [RL-1:0] pat, cpat;
    exp_t got_x;
    rst_n = 1'b0;
    start_valid = 1'b0;
    a_val = '0;
    b_val = '0;
    dout = 1'b0;
    C = 1'b0;
    res_ready = 1'b0;

    fork
      forever begin
        @(negedge clk);
        #2;
        if (res_valid && res_ready) begin
          if (sb.size() == 0) begin
            check("scoreboard_underflow", 1, 0);
          end else begin
            got_x = sb.pop_front();
            check("res_sum", int'(res_sum), got_x.sum);
            check("res_ovf", int'(res_ovf), got_x.ovf);
            check("res_err", int'(res_err), got_x.err);
          end
        end
      end
    join_none

    repeat (3) @(negedge clk);
    check("reset_outs", int'({A, B, en, read_or_write, res_valid, res_ovf, res_err}), 0);
    check("reset_sum", int'(res_sum), 0);
    check("reset_start_ready", int'(start_ready), 1);
    rst_n = 1'b1;
    @(negedge clk);

    run_txn(3, 2, ones(5), '0, 0);
    run_txn(0, 0, '0, '0, 0);
    cpat = '0;
    cpat[RL-1] = 1'b1;
    run_txn(15, 15, ones(30), cpat, 1);
    run_txn(20, 1, ones(16), '0, 2);
    pat = '0;
    pat[0] = 1'b1;
    pat[1] = 1'b1;
    pat[3] = 1'b1;
    run_txn(2, 1, pat, '0, 0);
    run_txn(4, 6, ones(10), '0, 10);
    reset_mid_send();
    run_txn(1, 1, ones(2), '0, 0);

    for (int t = 0; t < 25; t++) begin
      a = $urandom_range(0, 20);
      b = $urandom_range(0, 20);
      n = ((a > FL) ? FL : a) + ((b > FL) ? FL : b);
      mode = $urandom_range(0, 2);
      pat = ones(n);
      cpat = '0;
      if (mode == 1) pat = RL'($urandom);
      if (mode == 2) cpat[$urandom_range(0, RL - 1)] = 1'b1;
      run_txn(a, b, pat, cpat, $urandom_range(0, 3));
    end

    repeat (2) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
